// File: rtl/acc_job_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module : acc_job_scheduler_pkg
// Brief  : Opcode constants, select/state types and instruction decode helper
//          shared by the accelerator job scheduler.
// Rev    : 1.0
// ============================================================================
package acc_job_scheduler_pkg;

    localparam logic [5:0] c_op_header = 6'b111111;
    localparam logic [2:0] c_op_fft    = 3'b001;
    localparam logic [2:0] c_op_fir    = 3'b011;
    localparam logic [2:0] c_op_iir    = 3'b111;

    typedef enum logic [1:0] {
        SEL_FFT = 2'd0,
        SEL_FIR = 2'd1,
        SEL_IIR = 2'd2
    } acc_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic     valid;
        acc_sel_t sel;
    } instr_dec_t;

    function automatic instr_dec_t decode_instr(input logic [31:0] instr);
        instr_dec_t dec;
        dec.valid = 1'b0;
        dec.sel   = SEL_FFT;
        if (instr[31:3] == {c_op_header, 23'b0}) begin
            case (instr[2:0])
                c_op_fft: begin dec.valid = 1'b1; dec.sel = SEL_FFT; end
                c_op_fir: begin dec.valid = 1'b1; dec.sel = SEL_FIR; end
                c_op_iir: begin dec.valid = 1'b1; dec.sel = SEL_IIR; end
                default:  dec.valid = 1'b0;
            endcase
        end
        return dec;
    endfunction

    // Bit order {iir, fir, fft} matches the enable and done vectors in the top.
    function automatic logic [2:0] sel_onehot(input acc_sel_t sel);
        logic [2:0] oh;
        case (sel)
            SEL_FFT: oh = 3'b001;
            SEL_FIR: oh = 3'b010;
            SEL_IIR: oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/acc_job_scheduler_fifo.sv
`default_nettype none
// ============================================================================
// Module : acc_job_scheduler_fifo
// Brief  : DEPTH-entry queue of accelerator selects with wrap pointers and an
//          occupancy count; simultaneous push and pop are both honoured.
// Rev    : 1.0
// ============================================================================
module acc_job_scheduler_fifo
    import acc_job_scheduler_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  acc_sel_t         i_din,
    output acc_sel_t         o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [PTR_W:0]   o_count
);

    localparam logic [PTR_W:0] c_full_count = (PTR_W + 1)'(DEPTH);

    acc_sel_t         mem_q [DEPTH];
    acc_sel_t         mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (count_q == c_full_count);
    assign o_empty   = (count_q == '0);
    assign o_count   = count_q;
    assign o_dout    = mem_q[rd_ptr_q];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) begin
            mem_d[wr_ptr_q] = i_din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: entries are only read once the count says they are valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/acc_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module : acc_job_scheduler
// Brief  : Queues host accelerator instructions and runs them one at a time,
//          handshaking on read/write done with timeout and error reporting.
// Rev    : 1.0
// ============================================================================
module acc_job_scheduler
    import acc_job_scheduler_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int PTR_W   = 2,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chipselect,
    input  logic [31:0]      instruction,
    output logic             instr_ready,
    input  logic             fft_read_done,
    input  logic             fft_write_done,
    input  logic             fir_read_done,
    input  logic             fir_write_done,
    input  logic             iir_read_done,
    input  logic             iir_write_done,
    output logic             fft_enable,
    output logic             fir_enable,
    output logic             iir_enable,
    output logic             acc_done,
    output logic             acc_error,
    output logic             busy,
    output logic [PTR_W:0]   queue_count
);

    localparam logic [TO_W-1:0] c_timeout_last = TO_W'(TIMEOUT - 1);

    sched_state_t     state_q, state_d;
    acc_sel_t         sel_q, sel_d;
    logic [TO_W-1:0]  timer_q, timer_d;
    logic [2:0]       enable_q, enable_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    instr_dec_t       w_dec;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_invalid;
    acc_sel_t         w_head_sel;
    logic             w_full;
    logic             w_empty;
    logic [2:0]       w_sel_mask;
    logic             w_sel_rd;
    logic             w_sel_wr;

    assign w_dec     = decode_instr(instruction);
    assign w_accept  = chipselect & ~w_full;
    assign w_push    = w_accept & w_dec.valid;
    assign w_invalid = w_accept & ~w_dec.valid;

    acc_job_scheduler_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_dec.sel),
        .o_dout  (w_head_sel),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (queue_count)
    );

    // Done pair of the latched job only; other accelerators' dones are masked off.
    assign w_sel_mask = sel_onehot(sel_q);
    assign w_sel_rd   = |(w_sel_mask & {iir_read_done,  fir_read_done,  fft_read_done});
    assign w_sel_wr   = |(w_sel_mask & {iir_write_done, fir_write_done, fft_write_done});

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        timer_d  = timer_q;
        enable_d = enable_q;
        done_d   = 1'b0;
        error_d  = w_invalid;
        w_pop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop    = 1'b1;
                    sel_d    = w_head_sel;
                    enable_d = sel_onehot(w_head_sel);
                    timer_d  = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                timer_d = timer_q + 1'b1;
                if (w_sel_rd && w_sel_wr) begin
                    enable_d = '0;
                    done_d   = 1'b1;
                    state_d  = ST_DRAIN;
                end else if (timer_q == c_timeout_last) begin
                    enable_d = '0;
                    error_d  = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!w_sel_rd && !w_sel_wr) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                enable_d = '0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sel_q    <= SEL_FFT;
            timer_q  <= '0;
            enable_q <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            timer_q  <= timer_d;
            enable_q <= enable_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign instr_ready = ~w_full;
    assign fft_enable  = enable_q[0];
    assign fir_enable  = enable_q[1];
    assign iir_enable  = enable_q[2];
    assign acc_done    = done_q;
    assign acc_error   = error_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_acc_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_acc_job_scheduler
// Brief  : Randomized self-checking bench comparing the scheduler against a
//          job-queue reference model, including timeouts and mid-job reset.
// Rev    : 1.0
// ============================================================================
module tb_acc_job_scheduler;

    localparam int DEPTH   = 4;
    localparam int PTR_W   = 2;
    localparam int TIMEOUT = 16;
    localparam int TO_W    = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             chipselect = 1'b0;
    logic [31:0]      instruction = '0;
    logic [2:0]       rd_v = '0;
    logic [2:0]       wr_v = '0;
    logic             instr_ready;
    logic             fft_enable, fir_enable, iir_enable;
    logic             acc_done, acc_error, busy;
    logic [PTR_W:0]   queue_count;

    acc_job_scheduler #(
        .DEPTH   (DEPTH),
        .PTR_W   (PTR_W),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .chipselect     (chipselect),
        .instruction    (instruction),
        .instr_ready    (instr_ready),
        .fft_read_done  (rd_v[0]),
        .fft_write_done (wr_v[0]),
        .fir_read_done  (rd_v[1]),
        .fir_write_done (wr_v[1]),
        .iir_read_done  (rd_v[2]),
        .iir_write_done (wr_v[2]),
        .fft_enable     (fft_enable),
        .fir_enable     (fir_enable),
        .iir_enable     (iir_enable),
        .acc_done       (acc_done),
        .acc_error      (acc_error),
        .busy           (busy),
        .queue_count    (queue_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: a queue of waiting jobs plus the job currently owned.
    int         mq[$];
    int         m_cur;
    int         m_phase;     // 0 waiting for work, 1 accelerator running, 2 waiting for done release
    int         m_runcnt;
    logic [2:0] m_en;
    logic       m_done;
    logic       m_err;
    int         n_timeouts = 0;
    int         n_completes = 0;

    logic [31:0] valid_tab [3] = '{32'hFC00_0001, 32'hFC00_0003, 32'hFC00_0007};

    task automatic model_reset();
        mq.delete();
        m_cur    = 0;
        m_phase  = 0;
        m_runcnt = 0;
        m_en     = '0;
        m_done   = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic model_step();
        bit ready, acc, valid;
        int code;
        ready = (mq.size() < DEPTH);
        acc   = chipselect && ready;
        valid = 0;
        code  = 0;
        if ((instruction >> 3) == 32'h1F80_0000) begin
            case (instruction & 32'd7)
                32'd1: begin valid = 1; code = 0; end
                32'd3: begin valid = 1; code = 1; end
                32'd7: begin valid = 1; code = 2; end
                default: valid = 0;
            endcase
        end
        m_done = 1'b0;
        m_err  = acc && !valid;
        if (m_phase == 0) begin
            if (mq.size() > 0) begin
                m_cur    = mq.pop_front();
                m_en     = '0;
                m_en[m_cur] = 1'b1;
                m_runcnt = 0;
                m_phase  = 1;
            end
        end else if (m_phase == 1) begin
            m_runcnt++;
            if (rd_v[m_cur] && wr_v[m_cur]) begin
                m_en    = '0;
                m_done  = 1'b1;
                m_phase = 2;
                n_completes++;
            end else if (m_runcnt == TIMEOUT) begin
                m_en    = '0;
                m_err   = 1'b1;
                m_phase = 0;
                n_timeouts++;
            end
        end else begin
            if (!rd_v[m_cur] && !wr_v[m_cur]) m_phase = 0;
        end
        if (acc && valid) mq.push_back(code);
    endtask

    task automatic check_outputs();
        chk("fft_enable",  fft_enable,  m_en[0]);
        chk("fir_enable",  fir_enable,  m_en[1]);
        chk("iir_enable",  iir_enable,  m_en[2]);
        chk("acc_done",    acc_done,    m_done);
        chk("acc_error",   acc_error,   m_err);
        chk("busy",        busy,        m_phase != 0);
        chk("queue_count", queue_count, mq.size());
    endtask

    // mode 0: dones eventually follow the enable; mode 1: running accelerator never answers
    task automatic drive(input int mode);
        int r;
        chipselect = ($urandom % (mode == 0 ? 3 : 8)) == 0;
        r = $urandom % 10;
        if (r < 7)       instruction = valid_tab[r % 3];
        else if (r == 7) instruction = 32'hFC00_0002;
        else if (r == 8) instruction = 32'hFC00_0009;
        else             instruction = $urandom;
        for (int i = 0; i < 3; i++) begin
            if (m_en[i]) begin
                if (mode == 0) begin
                    if ($urandom % 5 == 0) rd_v[i] = 1'b1;
                    if ($urandom % 5 == 0) wr_v[i] = 1'b1;
                end else begin
                    rd_v[i] = 1'b0;
                    wr_v[i] = 1'b0;
                end
            end else begin
                if ($urandom % 4 == 0) rd_v[i] = ~rd_v[i];
                if ($urandom % 4 == 0) wr_v[i] = ~wr_v[i];
            end
        end
    endtask

    task automatic cycle(input int mode);
        @(negedge clk);
        drive(mode);
        #1;
        chk("instr_ready", instr_ready, mq.size() < DEPTH);
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        chk("instr_ready_rst", instr_ready, 1'b1);
        @(negedge clk);
        reset = 1'b0;

        repeat (600) cycle(0);
        repeat (250) cycle(1);

        // Look for a running job with at least two waiting, then reset mid-job.
        for (int k = 0; k < 300; k++) begin
            if (m_phase == 1 && mq.size() >= 2) break;
            cycle(0);
        end
        @(negedge clk);
        chipselect = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        reset = 1'b0;

        repeat (600) cycle(0);

        chk("saw_timeout",    n_timeouts  > 0, 1'b1);
        chk("saw_completion", n_completes > 0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
